// File: rtl/adc_test_pattern_gen_pkg.sv
// Shared types, generator constants and pattern helpers for the ADC test pattern generator.
package adc_test_pattern_gen_pkg;

  typedef enum logic [3:0] {
    MODE_NORMAL   = 4'b0000,
    MODE_MIDSCALE = 4'b0001,
    MODE_POS_FS   = 4'b0010,
    MODE_NEG_FS   = 4'b0011,
    MODE_CHECKER  = 4'b0100,
    MODE_PN23     = 4'b0101,
    MODE_PN9      = 4'b0110,
    MODE_TOGGLE   = 4'b0111,
    MODE_USER     = 4'b1000,
    MODE_RAMP     = 4'b1111
  } test_mode_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  localparam logic [22:0] PN23_SEED   = '1;
  localparam logic [8:0]  PN9_SEED    = '1;
  localparam int unsigned PN23_TAP_A  = 22;
  localparam int unsigned PN23_TAP_B  = 17;
  localparam int unsigned PN9_TAP_A   = 8;
  localparam int unsigned PN9_TAP_B   = 4;

  // Word is right-justified in 16 bits; MSB of the w-bit word is 1 when inv=0.
  function automatic logic [15:0] checker_word(int unsigned w, logic inv);
    return (inv ? 16'h5555 : 16'hAAAA) >> (16 - w);
  endfunction

  function automatic logic [15:0] midscale_word(int unsigned w);
    return 16'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/adc_test_pattern_gen_seq.sv
// Per-channel user-pattern sequencer: walks the user words, loops or stops after one pass.
//   state    | meaning
//   SEQ_IDLE | not in user mode, index parked at 0
//   SEQ_RUN  | emitting pattern[index]
//   SEQ_DONE | single pass finished, emitting zeros with done high
module test_pattern_seq
  import adc_test_pattern_gen_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int PAT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    user_mode_i,
  input  logic                    single_pass_i,
  input  logic [PAT_DEPTH*16-1:0] user_pattern_i,
  output logic [DATA_W-1:0]       user_word_o,
  output logic                    user_done_o
);

  localparam int IDX_W = $clog2(PAT_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_DEPTH - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [15:0]      pat [PAT_DEPTH];
  logic [15:0]      pat_sel;

  for (genvar i = 0; i < PAT_DEPTH; i++) begin : g_pat
    assign pat[i] = user_pattern_i[i*16 +: 16];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // IDLE behaves as RUN at index 0, so entering user mode emits pattern[0] immediately.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (!user_mode_i) begin
      state_d = SEQ_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        SEQ_IDLE, SEQ_RUN: begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = single_pass_i ? SEQ_DONE : SEQ_RUN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEQ_RUN;
          end
        end
        SEQ_DONE: done_d = 1'b1;
        default:  state_d = SEQ_IDLE;
      endcase
    end
  end

  always_comb begin
    pat_sel     = pat[idx_q];
    user_word_o = (state_q == SEQ_DONE) ? '0 : DATA_W'(pat_sel >> (16 - DATA_W));
    user_done_o = done_q;
  end

endmodule

// File: rtl/adc_test_pattern_gen.sv
// ADC test pattern generator: per-channel registered mux over shared PN23/PN9/ramp/toggle
// generators and a per-channel user-pattern sequencer.
module adc_test_pattern_gen
  import adc_test_pattern_gen_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int N_CH      = 2,
  parameter int PAT_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   normal_data,
  input  logic [N_CH*4-1:0]        select_mode,
  input  logic                     user_test_mode_control,
  input  logic                     reset_PN_long_gen,
  input  logic                     reset_PN_short_gen,
  input  logic [PAT_DEPTH*16-1:0]  user_pattern,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [N_CH-1:0]          user_done
);

  localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(midscale_word(DATA_W));
  localparam logic [DATA_W-1:0] CHECK_A  = DATA_W'(checker_word(DATA_W, 1'b0));
  localparam logic [DATA_W-1:0] CHECK_B  = DATA_W'(checker_word(DATA_W, 1'b1));

  logic [22:0]       pn23_q;
  logic [8:0]        pn9_q;
  logic [DATA_W-1:0] ramp_q;
  logic              phase_q;
  logic [DATA_W-1:0] pn23_word, pn9_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pn23_q  <= PN23_SEED;
      pn9_q   <= PN9_SEED;
      ramp_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      pn23_q  <= reset_PN_long_gen ? PN23_SEED
               : {pn23_q[21:0], pn23_q[PN23_TAP_A] ^ pn23_q[PN23_TAP_B]};
      pn9_q   <= reset_PN_short_gen ? PN9_SEED
               : {pn9_q[7:0], pn9_q[PN9_TAP_A] ^ pn9_q[PN9_TAP_B]};
      ramp_q  <= ramp_q + DATA_W'(1);
      phase_q <= ~phase_q;
    end
  end

  // Both PN words are MSB-aligned into DATA_W bits.
  assign pn23_word = DATA_W'({pn23_q, 9'b0} >> (32 - DATA_W));
  assign pn9_word  = DATA_W'({pn9_q, 7'b0} >> (16 - DATA_W));

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    test_mode_e        mode;
    logic [DATA_W-1:0] user_word, word_d, word_q, nd;

    assign mode = test_mode_e'(select_mode[c*4 +: 4]);
    assign nd   = normal_data[c*DATA_W +: DATA_W];

    test_pattern_seq #(
      .DATA_W    (DATA_W),
      .PAT_DEPTH (PAT_DEPTH)
    ) u_seq (
      .clk            (clk),
      .rst            (rst),
      .user_mode_i    (mode == MODE_USER),
      .single_pass_i  (user_test_mode_control),
      .user_pattern_i (user_pattern),
      .user_word_o    (user_word),
      .user_done_o    (user_done[c])
    );

    always_comb begin
      word_d = nd;
      case (mode)
        MODE_NORMAL:   word_d = nd;
        MODE_MIDSCALE: word_d = MIDSCALE;
        MODE_POS_FS:   word_d = '1;
        MODE_NEG_FS:   word_d = '0;
        MODE_CHECKER:  word_d = phase_q ? CHECK_B : CHECK_A;
        MODE_PN23:     word_d = pn23_word;
        MODE_PN9:      word_d = pn9_word;
        MODE_TOGGLE:   word_d = phase_q ? '0 : '1;
        MODE_USER:     word_d = user_word;
        MODE_RAMP:     word_d = ramp_q;
        default:       word_d = nd;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) word_q <= '0;
      else     word_q <= word_d;
    end

    assign out_data[c*DATA_W +: DATA_W] = word_q;
  end

endmodule

// File: tb/tb_adc_test_pattern_gen.sv
// Self-checking bench for adc_test_pattern_gen (DATA_W=14, N_CH=2, PAT_DEPTH=4).
module tb_adc_test_pattern_gen;

  localparam int W  = 14;
  localparam int NC = 2;
  localparam int PD = 4;
  localparam int NBITS = 40100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC*W-1:0]   normal_data;
  logic [NC*4-1:0]   select_mode;
  logic              ctrl;
  logic              rlong;
  logic              rshort;
  logic [PD*16-1:0]  user_pattern;
  logic [NC*W-1:0]   out_data;
  logic [NC-1:0]     user_done;

  adc_test_pattern_gen #(.DATA_W(W), .N_CH(NC), .PAT_DEPTH(PD)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .normal_data            (normal_data),
    .select_mode            (select_mode),
    .user_test_mode_control (ctrl),
    .reset_PN_long_gen      (rlong),
    .reset_PN_short_gen     (rshort),
    .user_pattern           (user_pattern),
    .out_data               (out_data),
    .user_done              (user_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: counts of edges since reset / since reseed, plus per-channel pass progress.
  int          m_n, m_t23, m_t9;
  int          m_idx [NC];
  bit          m_fin [NC];
  logic [W-1:0] exp_out [NC];
  logic         exp_done [NC];
  bit pn23_bits [NBITS];
  bit pn9_bits  [NBITS];
  logic [W-1:0] user_exp [PD];

  function automatic logic [W-1:0] pn23_word(int t);
    logic [W-1:0] r = '0;
    for (int j = 0; j < W; j++) r = {r[W-2:0], pn23_bits[t+j]};
    return r;
  endfunction

  function automatic logic [W-1:0] pn9_word(int t);
    logic [8:0] r = '0;
    for (int j = 0; j < 9; j++) r = {r[7:0], pn9_bits[t+j]};
    return {r, 5'b0};
  endfunction

  task automatic model_reset();
    m_n = 0; m_t23 = 0; m_t9 = 0;
    for (int c = 0; c < NC; c++) begin m_idx[c] = 0; m_fin[c] = 1'b0; end
  endtask

  task automatic set_mode(int c, logic [3:0] m);
    select_mode[c*4 +: 4] = m;
  endtask

  // Predict the outputs of the coming edge from current inputs, advance the model, take the edge.
  task automatic tick();
    logic [3:0]  md;
    logic [15:0] pw;
    for (int c = 0; c < NC; c++) begin
      md = select_mode[c*4 +: 4];
      exp_done[c] = 1'b0;
      case (md)
        4'h0: exp_out[c] = normal_data[c*W +: W];
        4'h1: exp_out[c] = 14'h2000;
        4'h2: exp_out[c] = 14'h3FFF;
        4'h3: exp_out[c] = 14'h0000;
        4'h4: exp_out[c] = (m_n % 2 == 0) ? 14'h2AAA : 14'h1555;
        4'h5: exp_out[c] = pn23_word(m_t23);
        4'h6: exp_out[c] = pn9_word(m_t9);
        4'h7: exp_out[c] = (m_n % 2 == 0) ? 14'h3FFF : 14'h0000;
        4'h8: begin
          if (m_fin[c]) begin
            exp_out[c] = '0;
            exp_done[c] = 1'b1;
          end else begin
            pw = user_pattern[m_idx[c]*16 +: 16];
            exp_out[c] = pw[15:2];
            if (m_idx[c] == PD-1) begin
              if (ctrl) m_fin[c] = 1'b1;
              else      m_idx[c] = 0;
            end else begin
              m_idx[c]++;
            end
          end
        end
        4'hF: exp_out[c] = W'(m_n % 16384);
        default: exp_out[c] = normal_data[c*W +: W];
      endcase
      if (md != 4'h8) begin m_idx[c] = 0; m_fin[c] = 1'b0; end
    end
    m_n++;
    m_t23 = rlong  ? 0 : m_t23 + 1;
    m_t9  = rshort ? 0 : m_t9 + 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_out: got %h expected 0", out_data);
    end
    n_assert++;
    if (user_done !== '0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", user_done);
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_checker_midscale();
    logic [W-1:0] cexp;
    set_mode(0, 4'h4); set_mode(1, 4'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      cexp = (k % 2 == 0) ? 14'h2AAA : 14'h1555;
      n_assert++;
      if (out_data[0 +: W] !== cexp || exp_out[0] !== cexp) begin
        n_fail++; $display("FAIL checker k=%0d: got %h expected %h", k, out_data[0 +: W], cexp);
      end
      n_assert++;
      if (out_data[W +: W] !== 14'h2000) begin
        n_fail++; $display("FAIL midscale k=%0d: got %h expected 2000", k, out_data[W +: W]);
      end
    end
  endtask

  task automatic test_user_repeat();
    ctrl = 1'b0;
    set_mode(0, 4'h8); set_mode(1, 4'h0);
    for (int k = 0; k < 10; k++) begin
      normal_data[W +: W] = W'($urandom);
      tick();
      n_assert++;
      if (out_data[0 +: W] !== user_exp[k % PD] || user_done[0] !== 1'b0) begin
        n_fail++; $display("FAIL user_repeat k=%0d: got %h/%b expected %h/0",
                           k, out_data[0 +: W], user_done[0], user_exp[k % PD]);
      end
      n_assert++;
      if (out_data[W +: W] !== exp_out[1]) begin
        n_fail++; $display("FAIL normal_ch1 k=%0d: got %h expected %h", k, out_data[W +: W], exp_out[1]);
      end
    end
  endtask

  task automatic test_user_single();
    logic [W-1:0] wexp;
    logic         dexp;
    set_mode(0, 4'h0);
    tick();
    ctrl = 1'b1;
    set_mode(0, 4'h8);
    for (int k = 0; k < 7; k++) begin
      tick();
      wexp = (k < PD) ? user_exp[k] : '0;
      dexp = (k >= PD);
      n_assert++;
      if (out_data[0 +: W] !== wexp || user_done[0] !== dexp) begin
        n_fail++; $display("FAIL user_single k=%0d: got %h/%b expected %h/%b",
                           k, out_data[0 +: W], user_done[0], wexp, dexp);
      end
    end
  endtask

  task automatic test_user_restart();
    set_mode(0, 4'h0);
    normal_data[0 +: W] = 14'h0ABC;
    tick();
    n_assert++;
    if (out_data[0 +: W] !== 14'h0ABC || user_done[0] !== 1'b0) begin
      n_fail++; $display("FAIL restart_gap: got %h/%b expected 0abc/0", out_data[0 +: W], user_done[0]);
    end
    set_mode(0, 4'h8);
    tick();
    n_assert++;
    if (out_data[0 +: W] !== 14'h048D || user_done[0] !== 1'b0) begin
      n_fail++; $display("FAIL restart_first: got %h/%b expected 048d/0", out_data[0 +: W], user_done[0]);
    end
  endtask

  task automatic test_pn23();
    set_mode(0, 4'h5); set_mode(1, 4'h5);
    rlong = 1'b1;
    tick();
    rlong = 1'b0;
    tick();
    for (int c = 0; c < NC; c++) begin
      n_assert++;
      if (out_data[c*W +: W] !== 14'h3FFF) begin
        n_fail++; $display("FAIL pn23_seed ch%0d: got %h expected 3fff", c, out_data[c*W +: W]);
      end
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        n_assert++;
        if (out_data[c*W +: W] !== exp_out[c]) begin
          n_fail++; $display("FAIL pn23 k=%0d ch%0d: got %h expected %h", k, c, out_data[c*W +: W], exp_out[c]);
        end
      end
    end
  endtask

  task automatic test_pn9();
    set_mode(0, 4'h6); set_mode(1, 4'h6);
    rshort = 1'b1;
    tick();
    rshort = 1'b0;
    tick();
    n_assert++;
    if (out_data[0 +: W] !== 14'h3FE0) begin
      n_fail++; $display("FAIL pn9_seed: got %h expected 3fe0", out_data[0 +: W]);
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        n_assert++;
        if (out_data[c*W +: W] !== exp_out[c]) begin
          n_fail++; $display("FAIL pn9 k=%0d ch%0d: got %h expected %h", k, c, out_data[c*W +: W], exp_out[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 7) == 0)
          set_mode(c, ($urandom_range(0, 2) == 0) ? 4'h8 : 4'($urandom_range(0, 15)));
      end
      normal_data = {W'($urandom), W'($urandom)};
      if ($urandom_range(0, 5) == 0) ctrl = ~ctrl;
      rlong  = ($urandom_range(0, 15) == 0);
      rshort = ($urandom_range(0, 15) == 0);
      tick();
      for (int c = 0; c < NC; c++) begin
        n_assert++;
        if (out_data[c*W +: W] !== exp_out[c] || user_done[c] !== exp_done[c]) begin
          n_fail++; $display("FAIL random k=%0d ch%0d: got %h/%b expected %h/%b",
                             k, c, out_data[c*W +: W], user_done[c], exp_out[c], exp_done[c]);
        end
      end
    end
    rlong = 1'b0; rshort = 1'b0;
  endtask

  task automatic test_ramp();
    logic [W-1:0] rexp [3];
    int guard = 0;
    rexp[0] = 14'h3FFE; rexp[1] = 14'h3FFF; rexp[2] = 14'h0000;
    set_mode(0, 4'hF); set_mode(1, 4'hF);
    while ((m_n % 16384) != 16382 && guard < 20000) begin
      tick();
      guard++;
    end
    n_assert++;
    if (guard >= 20000) begin
      n_fail++; $display("FAIL ramp_timeout: got %0d cycles expected < 20000", guard);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        n_assert++;
        if (out_data[c*W +: W] !== rexp[k] || exp_out[c] !== rexp[k]) begin
          n_fail++; $display("FAIL ramp_wrap k=%0d ch%0d: got %h expected %h", k, c, out_data[c*W +: W], rexp[k]);
        end
      end
    end
  endtask

  task automatic test_rst_mid_run();
    ctrl = 1'b0;
    set_mode(0, 4'h0); set_mode(1, 4'hF);
    tick();
    set_mode(0, 4'h8);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if (out_data !== '0 || user_done !== '0) begin
      n_fail++; $display("FAIL rst_async: got %h/%b expected 0/0", out_data, user_done);
    end
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    tick();
    n_assert++;
    if (out_data[0 +: W] !== 14'h048D || out_data[0 +: W] !== exp_out[0]) begin
      n_fail++; $display("FAIL rst_restart: got %h expected 048d", out_data[0 +: W]);
    end
    n_assert++;
    if (out_data[W +: W] !== 14'h0000) begin
      n_fail++; $display("FAIL rst_ramp: got %h expected 0000", out_data[W +: W]);
    end
  endtask

  initial begin
    rst = 1'b1;
    normal_data = '0;
    select_mode = '0;
    ctrl = 1'b0; rlong = 1'b0; rshort = 1'b0;
    user_pattern = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    user_exp[0] = 14'h048D; user_exp[1] = 14'h159E;
    user_exp[2] = 14'h26AF; user_exp[3] = 14'h37BC;
    for (int n = 0; n < NBITS; n++) begin
      pn23_bits[n] = (n < 23) ? 1'b1 : (pn23_bits[n-23] ^ pn23_bits[n-18]);
      pn9_bits[n]  = (n < 9)  ? 1'b1 : (pn9_bits[n-9] ^ pn9_bits[n-5]);
    end
    model_reset();
    #2;
    test_reset();
    test_checker_midscale();
    test_user_repeat();
    test_user_single();
    test_user_restart();
    test_pn23();
    test_pn9();
    test_random();
    test_ramp();
    test_rst_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
